banco_registradores_param: RTL and testbench

//  Parametrised register bank: 2^AddrW entries of Size bits, two combinational read ports, one write port.

---
 rtl/banco_registradores_param_pkg.sv | 12 +
 rtl/banco_sweep_ctrl.sv | 72 +++++++
 rtl/banco_registradores_param.sv | 95 +++++++++
 tb/tb_banco_registradores_param.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/banco_registradores_param_pkg.sv
// Shared definitions for the register bank: FSM state encoding and default sizes.
package banco_registradores_param_pkg;

  localparam int SIZE_DEF  = 8;
  localparam int ADDRW_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/banco_sweep_ctrl.sv
// Clear-sweep sequencer: two-state FSM, sweep index, registered busy, and IDLE gating of we/rsv.
module banco_sweep_ctrl
  import banco_registradores_param_pkg::*;
#(
  parameter int AddrW = ADDRW_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             we,
  input  logic             rsv,
  input  logic             clr_req,
  output logic             we_en,
  output logic             rsv_en,
  output logic [AddrW-1:0] sweep_idx,
  output logic             busy,
  output state_e           state_o
);

  localparam logic [AddrW-1:0] LAST_IDX = '1;

  state_e           state_q, state_d;
  logic [AddrW-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    we_en   = 1'b0;
    rsv_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        we_en  = we;
        rsv_en = rsv;
        if (clr_req) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SWEEP: begin
        // idx wraps back to 0 on the final step, so no terminal state is needed.
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign sweep_idx = idx_q;
  assign busy      = busy_q;
  assign state_o   = state_q;

endmodule

// File: rtl/banco_registradores_param.sv
// Register bank with per-entry pending bits and a sequenced clear sweep.
// Optional same-cycle write bypass on the read ports: BANCO_WRITE_BYPASS_EN.
module banco_registradores_param
  import banco_registradores_param_pkg::*;
#(
  parameter int Size  = SIZE_DEF,
  parameter int AddrW = ADDRW_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             we,
  input  logic [AddrW-1:0] wa,
  input  logic [Size-1:0]  wd,
  input  logic             rsv,
  input  logic [AddrW-1:0] rsv_a,
  input  logic             clr_req,
  input  logic [AddrW-1:0] a1,
  input  logic [AddrW-1:0] a2,
  output logic [Size-1:0]  rd1,
  output logic [Size-1:0]  rd2,
  output logic             pend1,
  output logic             pend2,
  output logic             busy
);

  localparam int Depth = 2 ** AddrW;

  logic [Size-1:0]  mem_q [Depth];
  logic [Size-1:0]  mem_d [Depth];
  logic [Depth-1:0] pend_q, pend_d;

  logic             we_en, rsv_en, sweep_en;
  logic [AddrW-1:0] sweep_idx;
  state_e           state_dbg;

  banco_sweep_ctrl #(.AddrW(AddrW)) u_ctrl (
    .clk       (clk),
    .clr_n     (clr_n),
    .we        (we),
    .rsv       (rsv),
    .clr_req   (clr_req),
    .we_en     (we_en),
    .rsv_en    (rsv_en),
    .sweep_idx (sweep_idx),
    .busy      (busy),
    .state_o   (state_dbg)
  );

  assign sweep_en = (state_dbg == ST_SWEEP);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= mem_d[i];
      pend_q <= pend_d;
    end
  end

  always_comb begin
    for (int i = 0; i < Depth; i++) mem_d[i] = mem_q[i];
    pend_d = pend_q;
    if (sweep_en) begin
      mem_d[sweep_idx]  = '0;
      pend_d[sweep_idx] = 1'b0;
    end else begin
      if (we_en) begin
        mem_d[wa]  = wd;
        pend_d[wa] = 1'b0;
      end
      // Reserve is applied after the write release so it wins on an address clash.
      if (rsv_en) pend_d[rsv_a] = 1'b1;
    end
  end

  always_comb begin
    rd1   = mem_q[a1];
    rd2   = mem_q[a2];
    pend1 = pend_q[a1];
    pend2 = pend_q[a2];
`ifdef BANCO_WRITE_BYPASS_EN
    // we_en is already gated off during a sweep, so bypass never fires while busy.
    if (we_en && (a1 == wa)) begin
      rd1   = wd;
      pend1 = rsv_en && (rsv_a == wa);
    end
    if (we_en && (a2 == wa)) begin
      rd2   = wd;
      pend2 = rsv_en && (rsv_a == wa);
    end
`endif
  end

endmodule

// File: tb/tb_banco_registradores_param.sv
// Directed, table-driven bench for banco_registradores_param (Size=8, AddrW=2).
module tb_banco_registradores_param;
  import banco_registradores_param_pkg::*;

  logic       clk, clr_n, we, rsv, clr_req;
  logic [1:0] wa, rsv_a, a1, a2;
  logic [7:0] wd, rd1, rd2;
  logic       pend1, pend2, busy;

  int n_checks = 0;
  int n_fail   = 0;

  banco_registradores_param #(.Size(8), .AddrW(2)) dut (
    .clk(clk), .clr_n(clr_n), .we(we), .wa(wa), .wd(wd), .rsv(rsv), .rsv_a(rsv_a),
    .clr_req(clr_req), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .pend1(pend1), .pend2(pend2), .busy(busy)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic       rsv;
    logic [1:0] rsv_a;
    logic [1:0] a1;
    logic [1:0] a2;
    logic [7:0] e_rd1;
    logic [7:0] e_rd2;
    logic       e_p1;
    logic       e_p2;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we = 0; wa = 0; wd = 0; rsv = 0; rsv_a = 0; clr_req = 0;
  endtask

  // Write one entry over a full cycle (inputs driven on negedge).
  task automatic write_entry(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    idle_inputs();
    we = 1; wa = addr; wd = data;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      a1 = 2'(i); a2 = 2'(3 - i);
      #1;
      chk({tag, "_rd1"}, rd1, 8'h00);
      chk({tag, "_rd2"}, rd2, 8'h00);
      chk({tag, "_pend1"}, {7'b0, pend1}, 8'h00);
      chk({tag, "_pend2"}, {7'b0, pend2}, 8'h00);
    end
  endtask

  // Starts a sweep with a clr_req pulse and counts the busy cycles (bounded).
  task automatic sweep_count(input string tag, input int exp_cycles, input bit poke_mid);
    int cnt;
    cnt = 0;
    @(negedge clk);
    idle_inputs();
    clr_req = 1;
    #1;
    chk({tag, "_busy_pre"}, {7'b0, busy}, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (busy) cnt++;
      else if (cnt > 0) break;
      if (poke_mid && cnt == 1) begin
        a1 = 0; a2 = 1;
        #1;
        chk({tag, "_live_rd1"}, rd1, 8'hFF);
        chk({tag, "_live_rd2"}, rd2, 8'hFF);
      end
      if (poke_mid && cnt == 2) begin
        we = 1; wa = 0; wd = 8'h55; rsv = 1; rsv_a = 0;
      end
    end
    chk({tag, "_busy_cycles"}, 8'(cnt), 8'(exp_cycles));
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{0, 2'd0, 8'h00, 0, 2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 0, 0};
    vecs[1]  = '{1, 2'd2, 8'hA5, 0, 2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 0, 0};
    vecs[2]  = '{1, 2'd3, 8'h3C, 0, 2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 0, 0};
    vecs[3]  = '{0, 2'd0, 8'h00, 0, 2'd0, 2'd2, 2'd3, 8'hA5, 8'h3C, 0, 0};
    vecs[4]  = '{0, 2'd0, 8'h00, 1, 2'd1, 2'd2, 2'd3, 8'hA5, 8'h3C, 0, 0};
    vecs[5]  = '{0, 2'd0, 8'h00, 0, 2'd0, 2'd1, 2'd0, 8'h00, 8'h00, 1, 0};
    vecs[6]  = '{1, 2'd1, 8'h11, 0, 2'd0, 2'd2, 2'd3, 8'hA5, 8'h3C, 0, 0};
    vecs[7]  = '{0, 2'd0, 8'h00, 0, 2'd0, 2'd1, 2'd1, 8'h11, 8'h11, 0, 0};
    vecs[8]  = '{1, 2'd1, 8'h22, 1, 2'd1, 2'd0, 2'd2, 8'h00, 8'hA5, 0, 0};
    vecs[9]  = '{0, 2'd0, 8'h00, 0, 2'd0, 2'd1, 2'd3, 8'h22, 8'h3C, 1, 0};
    vecs[10] = '{1, 2'd0, 8'h44, 1, 2'd3, 2'd1, 2'd2, 8'h22, 8'hA5, 1, 0};
    vecs[11] = '{0, 2'd0, 8'h00, 0, 2'd0, 2'd0, 2'd3, 8'h44, 8'h3C, 0, 1};
    vecs[12] = '{1, 2'd3, 8'h99, 0, 2'd0, 2'd0, 2'd1, 8'h44, 8'h22, 0, 1};
    vecs[13] = '{0, 2'd0, 8'h00, 0, 2'd0, 2'd3, 2'd3, 8'h99, 8'h99, 0, 0};

    idle_inputs();
    a1 = 0; a2 = 0;
    clr_n = 0;
    repeat (2) @(negedge clk);
    clr_n = 1;

    // Reset state
    check_all_zero("reset");
    chk("reset_busy", {7'b0, busy}, 8'h00);

    // Table-driven read/write/reserve vectors
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      rsv = vecs[i].rsv; rsv_a = vecs[i].rsv_a; clr_req = 0;
      a1 = vecs[i].a1; a2 = vecs[i].a2;
      #1;
      chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].e_rd1);
      chk($sformatf("vec%0d_rd2", i), rd2, vecs[i].e_rd2);
      chk($sformatf("vec%0d_pend1", i), {7'b0, pend1}, {7'b0, vecs[i].e_p1});
      chk($sformatf("vec%0d_pend2", i), {7'b0, pend2}, {7'b0, vecs[i].e_p2});
    end
    @(negedge clk);
    idle_inputs();

    // Sweep with dropped mid-sweep write/reserve
    for (int i = 0; i < 4; i++) write_entry(2'(i), 8'hFF);
    sweep_count("sweep", 4, 1'b1);
    check_all_zero("post_sweep");

    // Reset in the middle of a sweep, then a fresh full sweep
    for (int i = 0; i < 4; i++) write_entry(2'(i), 8'hFF);
    @(negedge clk);
    clr_req = 1;
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      @(negedge clk);
      clr_req = 0;
      #1;
      if (busy) cnt++;
    end
    chk("midrst_reached", 8'(cnt), 8'd2);
    #2;
    clr_n = 0;
    #1;
    chk("midrst_busy", {7'b0, busy}, 8'h00);
    chk("midrst_fsm", {7'b0, dut.u_ctrl.state_o}, {7'b0, ST_IDLE});
    check_all_zero("midrst");
    @(negedge clk);
    clr_n = 1;
    sweep_count("restart", 4, 1'b0);

    // Held clr_req: back-to-back sweeps with exactly one IDLE cycle between
    @(negedge clk);
    clr_req = 1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    chk("held_first", 8'(cnt), 8'd4);
    @(negedge clk);
    #1;
    chk("held_restart_busy", {7'b0, busy}, 8'h01);
    clr_req = 0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    #1;
    chk("held_end_busy", {7'b0, busy}, 8'h00);

    // Same-cycle write visibility on rd1
    write_entry(2'd0, 8'h12);
    @(negedge clk);
    we = 1; wa = 0; wd = 8'h7E; a1 = 0; a2 = 1;
    #1;
`ifdef BANCO_WRITE_BYPASS_EN
    chk("bypass_same", rd1, 8'h7E);
`else
    chk("nobypass_same", rd1, 8'h12);
`endif
    @(negedge clk);
    idle_inputs();
    #1;
    chk("write_next", rd1, 8'h7E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
